tvip_axi_burst_sequencer: RTL and testbench
===========================================

// Module: tvip_axi_burst_sequencer
// PURPOSE
//  Expands one AXI address-channel command (AW or AR) into a per-beat address stream for INCR, WRAP and FIXED bursts.
//  Sits between address-channel capture and the data-channel engine (W accept / R generate) in slave and memory models.
//  Each beat carries its address, index, byte-lane offset and last flag.
//  Illegal commands are flagged on every beat but still fully sequenced, so the data channel stays in step.
// PARAMETERS
//  ID_WIDTH       8    command ID width
//  ADDRESS_WIDTH  64   address width; all address arithmetic is modulo 2**ADDRESS_WIDTH
//  DATA_WIDTH     32   data bus width in bits; BUS_BYTES = DATA_WIDTH/8, LANE_BITS = $clog2(BUS_BYTES)
// PORTS
//  aclk               in   1              clock
//  areset             in   1              synchronous reset, active-high
//  cmd_valid          in   1              command valid
//  cmd_ready          out  1              command ready
//  cmd_id             in   ID_WIDTH       command ID
//  cmd_address        in   ADDRESS_WIDTH  start address
//  cmd_burst_length   in   8              encoded AxLEN (beats-1)
//  cmd_burst_size     in   3              encoded AxSIZE (bytes = 1<<size)
//  cmd_burst_type     in   2              00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  beat_valid         out  1              beat valid
//  beat_ready         in   1              beat ready
//  beat_id            out  ID_WIDTH       ID of the current command
//  beat_address       out  ADDRESS_WIDTH  beat address
//  beat_index         out  8              beat number, 0..AxLEN
//  beat_lane_offset   out  LANE_BITS      beat_address[LANE_BITS-1:0]
//  beat_last          out  1              final beat of the burst
//  beat_error         out  1              command illegal; constant for the whole burst
// BEHAVIOUR
//  Reset: state IDLE; beat_valid=0, beat_address/index/id=0, beat_last=0, beat_error=0; cmd_ready=0 while areset=1.
//  FSM IDLE -> BURST on cmd_valid&&cmd_ready; BURST -> IDLE on last-beat handshake with no new command accepted.
//  cmd_ready = (state==IDLE) || (beat_valid && beat_ready && beat_last): back-to-back commands, no bubble.
//  Latency: the command is latched at the accepting edge, and beat 0 is valid on the next cycle.
//  Handshake: beat_* stays stable while beat_valid && !beat_ready, and the beat advances only on a handshake.
//  beat_last = (beat_index == AxLEN); AxLEN=0 gives a single beat with last=1.
//  Address sizing: bytes = 1<<size and aligned = addr & ~(bytes-1). Beat 0 address is always cmd_address, unaligned addresses allowed.
//  FIXED: every beat uses cmd_address.
//  INCR: beat n (n>=1) address = aligned + n*bytes.
//  WRAP: wrap_bytes = bytes*(AxLEN+1), lower = addr & ~(wrap_bytes-1). next = cur+bytes; if next == lower+wrap_bytes then next = lower.
//  Error, latched at accept, high on every beat of the burst:
//   - bytes > BUS_BYTES, or burst type 11
//   - WRAP with AxLEN+1 not in {2,4,8,16}, or a start not aligned to bytes
//   - FIXED with AxLEN > 15
//   - INCR crossing 4KB: aligned[11:0] + (AxLEN+1)*bytes > 4096
//  Errored bursts still emit AxLEN+1 beats using the INCR/FIXED formulas; WRAP with an illegal length falls back to INCR addresses.
//  Reset mid-burst: the burst is abandoned immediately, with no further beats; the next command starts cleanly.
//  cmd_* is sampled only on the accepting cycle, and later changes are ignored.
// TESTING
//  1. INCR, AxLEN=3, size=2 (4B), addr 0x1002 -> beats 0x1002, 0x1004, 0x1008, 0x100C; last on index 3; error=0.
//  2. WRAP, AxLEN=3, size=2, addr 0x38 -> beats 0x38, 0x3C, 0x30, 0x34; lane offsets all 0.
//  3. FIXED, AxLEN=2, addr 0x200 with beat_ready low 3 cycles on beat 1 -> 0x200 x3; outputs held stable during the stall.
//  4. Errors:
//     - INCR, addr 0xFF8, size=3, AxLEN=1, DATA_WIDTH=64 -> 2 beats, error=1.
//     - WRAP, AxLEN=2 -> error=1.
//     - size=3 with DATA_WIDTH=32 -> error=1.
//  5. Back-to-back: cmd B valid during cmd A's last beat -> B accepted on that edge; beat_valid stays 1 and B beat 0 follows directly.
//  6. areset pulsed during beat 2 of an 8-beat INCR -> beat_valid=0 the next cycle; a new command then yields index 0 at its own address.

Source files
------------

// File: rtl/tvip_axi_burst_sequencer.sv
// Expands one AXI address-channel command (AW/AR) into a per-beat address
// stream for FIXED, INCR and WRAP bursts. A command is latched on its
// accepting edge and beat 0 is presented on the following cycle. Illegal
// commands are flagged on every beat and still emit AxLEN+1 beats, so the
// data channel stays in step.
module tvip_axi_burst_sequencer #(
    parameter int ID_WIDTH       = 8,
    parameter int ADDRESS_WIDTH  = 64,
    parameter int DATA_WIDTH     = 32,
    localparam int BUS_BYTES     = DATA_WIDTH / 8,
    localparam int LANE_BITS     = $clog2(BUS_BYTES)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ID_WIDTH-1:0]      cmd_id,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [7:0]               cmd_burst_length,
    input  logic [2:0]               cmd_burst_size,
    input  logic [1:0]               cmd_burst_type,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ID_WIDTH-1:0]      beat_id,
    output logic [ADDRESS_WIDTH-1:0] beat_address,
    output logic [7:0]               beat_index,
    output logic [LANE_BITS-1:0]     beat_lane_offset,
    output logic                     beat_last,
    output logic                     beat_error
);

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;
    localparam logic [1:0] BT_RSVD  = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;
    state_t state_q, state_d;

    // Burst context captured at accept
    logic [7:0]               len_q;
    logic [2:0]               size_q;
    logic                     fixed_q;
    logic                     wrap_q;
    logic [ADDRESS_WIDTH-1:0] cmd_addr_q;
    logic [ADDRESS_WIDTH-1:0] aligned_q;
    logic [ADDRESS_WIDTH-1:0] wrap_lower_q;
    logic [ADDRESS_WIDTH-1:0] wrap_end_q;

    logic beat_hs, last_hs, accept;

    assign beat_valid       = (state_q == BURST);
    assign beat_hs          = beat_valid && beat_ready;
    assign last_hs          = beat_hs && beat_last;
    // A new command may land on the same edge as the last-beat handshake.
    assign cmd_ready        = !areset && ((state_q == IDLE) || last_hs);
    assign accept           = cmd_valid && cmd_ready;
    assign beat_lane_offset = beat_address[LANE_BITS-1:0];

    // Command decode: address sizing, wrap window and legality
    logic [ADDRESS_WIDTH-1:0] c_bytes, c_aligned, c_wrap_bytes, c_lower;
    logic [8:0]               c_beats;
    logic [16:0]              c_span, c_incr_end;
    logic                     c_wrap_len_ok, c_unaligned, c_error;

    // Decode the incoming command so it can be latched in one edge
    always_comb begin
        c_beats       = {1'b0, cmd_burst_length} + 9'd1;
        c_bytes       = ADDRESS_WIDTH'(1) << cmd_burst_size;
        c_aligned     = cmd_address & ~(c_bytes - ADDRESS_WIDTH'(1));
        c_wrap_bytes  = ADDRESS_WIDTH'(c_beats) << cmd_burst_size;
        c_lower       = cmd_address & ~(c_wrap_bytes - ADDRESS_WIDTH'(1));
        // Largest span is 256 beats * 128 bytes, which fits in 17 bits.
        c_span        = 17'(c_beats) << cmd_burst_size;
        c_incr_end    = {5'd0, c_aligned[11:0]} + c_span;
        c_wrap_len_ok = (cmd_burst_length == 8'd1) || (cmd_burst_length == 8'd3) ||
                        (cmd_burst_length == 8'd7) || (cmd_burst_length == 8'd15);
        c_unaligned   = (cmd_address & (c_bytes - ADDRESS_WIDTH'(1))) != '0;
        c_error       = (32'(cmd_burst_size) > LANE_BITS) ||
                        (cmd_burst_type == BT_RSVD) ||
                        ((cmd_burst_type == BT_WRAP) && (!c_wrap_len_ok || c_unaligned)) ||
                        ((cmd_burst_type == BT_FIXED) && (cmd_burst_length > 8'd15)) ||
                        ((cmd_burst_type == BT_INCR) && (c_incr_end > 17'd4096));
    end

    // Next-beat address generation
    logic [ADDRESS_WIDTH-1:0] step, wrap_next, incr_next, next_addr;

    // Pick the following beat's address from the latched burst mode
    always_comb begin
        step      = ADDRESS_WIDTH'(1) << size_q;
        wrap_next = beat_address + step;
        incr_next = aligned_q + ((ADDRESS_WIDTH'(beat_index) + ADDRESS_WIDTH'(1)) << size_q);
        if (fixed_q)
            next_addr = cmd_addr_q;
        else if (wrap_q)
            next_addr = (wrap_next == wrap_end_q) ? wrap_lower_q : wrap_next;
        else
            next_addr = incr_next;
    end

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: stay in BURST across back-to-back commands
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (last_hs && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs and burst context; beats only advance on a handshake
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_id      <= '0;
            beat_address <= '0;
            beat_index   <= '0;
            beat_last    <= 1'b0;
            beat_error   <= 1'b0;
            len_q        <= '0;
            size_q       <= '0;
            fixed_q      <= 1'b0;
            wrap_q       <= 1'b0;
            cmd_addr_q   <= '0;
            aligned_q    <= '0;
            wrap_lower_q <= '0;
            wrap_end_q   <= '0;
        end else if (accept) begin
            beat_id      <= cmd_id;
            beat_address <= cmd_address;
            beat_index   <= '0;
            beat_last    <= (cmd_burst_length == 8'd0);
            beat_error   <= c_error;
            len_q        <= cmd_burst_length;
            size_q       <= cmd_burst_size;
            fixed_q      <= (cmd_burst_type == BT_FIXED);
            // Any illegal WRAP falls back to INCR addressing.
            wrap_q       <= (cmd_burst_type == BT_WRAP) && !c_error;
            cmd_addr_q   <= cmd_address;
            aligned_q    <= c_aligned;
            wrap_lower_q <= c_lower;
            wrap_end_q   <= c_lower + c_wrap_bytes;
        end else if (beat_hs && !beat_last) begin
            beat_address <= next_addr;
            beat_index   <= beat_index + 8'd1;
            beat_last    <= ((beat_index + 8'd1) == len_q);
        end
    end

endmodule

// File: tb/tb_tvip_axi_burst_sequencer.sv
// Self-checking bench for tvip_axi_burst_sequencer: table of directed
// commands, hand-written stall / back-to-back / reset sequences, and a
// randomized phase scored against a beat-list reference model.
module tb_tvip_axi_burst_sequencer;

    localparam int IDW = 8;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int BUS_BYTES = DW / 8;

    logic          aclk, areset;
    logic          cmd_valid, cmd_ready;
    logic [IDW-1:0] cmd_id;
    logic [AW-1:0] cmd_address;
    logic [7:0]    cmd_burst_length;
    logic [2:0]    cmd_burst_size;
    logic [1:0]    cmd_burst_type;
    logic          beat_valid, beat_ready;
    logic [IDW-1:0] beat_id;
    logic [AW-1:0] beat_address;
    logic [7:0]    beat_index;
    logic [1:0]    beat_lane_offset;
    logic          beat_last, beat_error;

    tvip_axi_burst_sequencer #(.ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_address(cmd_address), .cmd_burst_length(cmd_burst_length),
        .cmd_burst_size(cmd_burst_size), .cmd_burst_type(cmd_burst_type),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
        .beat_address(beat_address), .beat_index(beat_index),
        .beat_lane_offset(beat_lane_offset), .beat_last(beat_last), .beat_error(beat_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  idx;
        logic [1:0]  lane;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        logic [1:0]  bt;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [63:0] addr;
        logic        err;
        logic [63:0] a[4];
    } vec_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    beat_t  obs_q[$];
    beat_t  exp_q[$];
    vec_t   tbl[$];
    bit     sb_on = 0;
    bit     rand_done = 0;
    beat_t  mon_b;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic beat_t mk(input logic [7:0] id, input logic [63:0] a,
                                 input logic [7:0] idx, input logic last, input logic err);
        beat_t b;
        b.id = id; b.addr = a; b.idx = idx; b.lane = a[1:0]; b.last = last; b.err = err;
        return b;
    endfunction

    function automatic beat_t dut_beat();
        beat_t b;
        b = mk(beat_id, beat_address, beat_index, beat_last, beat_error);
        b.lane = beat_lane_offset;
        return b;
    endfunction

    function automatic void check_beat(input string nm, input beat_t act, input beat_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got id=%h addr=%h idx=%0d lane=%0d last=%b err=%b, want id=%h addr=%h idx=%0d lane=%0d last=%b err=%b",
                     nm, act.id, act.addr, act.idx, act.lane, act.last, act.err,
                     exp.id, exp.addr, exp.idx, exp.lane, exp.last, exp.err);
        end
    endfunction

    function automatic void check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    // Reference model: the full beat list of a command, from the burst rules.
    function automatic void model_push(input logic [1:0] bt, input logic [7:0] len, input logic [2:0] sz,
                                       input logic [63:0] addr, input logic [7:0] id);
        longint unsigned bytes, aligned, beats, wb, lower, a;
        bit err;
        bytes   = 64'd1 << sz;
        aligned = addr - (addr % bytes);
        beats   = 64'(len) + 1;
        err = 0;
        if (bytes > BUS_BYTES || bt == 2'b11) err = 1;
        if (bt == 2'b10 && !(beats == 2 || beats == 4 || beats == 8 || beats == 16)) err = 1;
        if (bt == 2'b10 && (addr % bytes) != 0) err = 1;
        if (bt == 2'b00 && len > 15) err = 1;
        if (bt == 2'b01 && (aligned % 4096) + beats * bytes > 4096) err = 1;
        wb    = bytes * beats;
        lower = addr - (addr % wb);
        for (int n = 0; n < int'(beats); n++) begin
            if (n == 0 || bt == 2'b00)     a = addr;
            else if (bt == 2'b10 && !err)  a = lower + ((addr - lower) + 64'(n) * bytes) % wb;
            else                           a = aligned + 64'(n) * bytes;
            exp_q.push_back(mk(id, a, 8'(n), (64'(n) == beats - 1), err));
        end
    endfunction

    function automatic void add_vec(input logic [1:0] bt, input logic [7:0] len, input logic [2:0] sz,
                                    input logic [63:0] addr, input logic err,
                                    input logic [63:0] a0, input logic [63:0] a1,
                                    input logic [63:0] a2, input logic [63:0] a3);
        vec_t v;
        v.bt = bt; v.len = len; v.sz = sz; v.addr = addr; v.err = err;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        tbl.push_back(v);
    endfunction

    // Beat collector; in scoreboard mode beats are checked against the model.
    always @(negedge aclk) begin
        if (!areset && beat_valid && beat_ready) begin
            mon_b = dut_beat();
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rand_extra_beat: got addr=%h idx=%0d, want no beat", mon_b.addr, mon_b.idx);
                end else begin
                    check_beat("rand_beat", mon_b, exp_q.pop_front());
                end
            end else begin
                obs_q.push_back(mon_b);
            end
        end
        if (sb_on && !areset && cmd_valid && cmd_ready)
            model_push(cmd_burst_type, cmd_burst_length, cmd_burst_size, cmd_address, cmd_id);
    end

    // Present a command and return at posedge+1 of the accepting edge.
    task automatic send_cmd(input logic [1:0] bt, input logic [7:0] len, input logic [2:0] sz,
                            input logic [63:0] a, input logic [7:0] id);
        int c = 0;
        bit ok = 0;
        cmd_valid = 1'b1; cmd_burst_type = bt; cmd_burst_length = len;
        cmd_burst_size = sz; cmd_address = a; cmd_id = id;
        while (!ok && c < 500) begin
            @(negedge aclk);
            if (cmd_ready) ok = 1;
            c++;
        end
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        cmd_address = {$urandom, $urandom};
        cmd_id = 8'($urandom);
        cmd_burst_length = 8'($urandom);
        cmd_burst_size = 3'($urandom);
        cmd_burst_type = 2'($urandom);
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 500 cycles, want 1");
        end
    endtask

    task automatic wait_obs(input int n, input string nm);
        int c = 0;
        while (obs_q.size() < n && c < 300) begin
            @(posedge aclk); #1;
            c++;
        end
        if (obs_q.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got %0d beats, want %0d", nm, obs_q.size(), n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        areset = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
        cmd_id = '0; cmd_address = '0; cmd_burst_length = '0; cmd_burst_size = '0; cmd_burst_type = '0;

        // Directed table: {type, len, size, addr, error, beat addresses}
        add_vec(2'b01, 8'd3, 3'd2, 64'h1002, 1'b0, 64'h1002, 64'h1004, 64'h1008, 64'h100C);
        add_vec(2'b10, 8'd3, 3'd2, 64'h0038, 1'b0, 64'h0038, 64'h003C, 64'h0030, 64'h0034);
        add_vec(2'b01, 8'd1, 3'd2, 64'h0FFC, 1'b1, 64'h0FFC, 64'h1000, 64'h0, 64'h0);
        add_vec(2'b10, 8'd2, 3'd2, 64'h0040, 1'b1, 64'h0040, 64'h0044, 64'h0048, 64'h0);
        add_vec(2'b01, 8'd1, 3'd3, 64'h0100, 1'b1, 64'h0100, 64'h0108, 64'h0, 64'h0);
        add_vec(2'b00, 8'd1, 3'd0, 64'h0123, 1'b0, 64'h0123, 64'h0123, 64'h0, 64'h0);
        add_vec(2'b01, 8'd0, 3'd1, 64'h0007, 1'b0, 64'h0007, 64'h0, 64'h0, 64'h0);
        add_vec(2'b11, 8'd1, 3'd2, 64'h0010, 1'b1, 64'h0010, 64'h0014, 64'h0, 64'h0);
        add_vec(2'b01, 8'd1, 3'd2, 64'h0FF8, 1'b0, 64'h0FF8, 64'h0FFC, 64'h0, 64'h0);
        add_vec(2'b10, 8'd1, 3'd2, 64'h0014, 1'b0, 64'h0014, 64'h0010, 64'h0, 64'h0);
        add_vec(2'b10, 8'd3, 3'd2, 64'h0039, 1'b1, 64'h0039, 64'h003C, 64'h0040, 64'h0044);

        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_beat_valid", 64'(beat_valid), 64'd0);
        check_val("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_beat("rst_beat", dut_beat(), mk(8'h0, 64'h0, 8'd0, 1'b0, 1'b0));
        areset = 1'b0;
        #1;
        check_val("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        beat_ready = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            obs_q.delete();
            send_cmd(tbl[i].bt, tbl[i].len, tbl[i].sz, tbl[i].addr, 8'(i + 16));
            wait_obs(int'(tbl[i].len) + 1, $sformatf("vec%0d", i));
            for (int n = 0; n <= int'(tbl[i].len); n++)
                if (obs_q.size() > 0)
                    check_beat($sformatf("vec%0d_beat%0d", i, n), obs_q.pop_front(),
                               mk(8'(i + 16), tbl[i].a[n], 8'(n), (n == int'(tbl[i].len)), tbl[i].err));
        end

        // FIXED burst stalled on beat 1 for three cycles
        obs_q.delete();
        send_cmd(2'b00, 8'd2, 3'd2, 64'h200, 8'h44);
        @(posedge aclk); #1;
        beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            check_val($sformatf("stall%0d_valid", k), 64'(beat_valid), 64'd1);
            check_beat($sformatf("stall%0d_beat", k), dut_beat(), mk(8'h44, 64'h200, 8'd1, 1'b0, 1'b0));
        end
        beat_ready = 1'b1;
        wait_obs(3, "fixed");
        for (int n = 0; n < 3; n++)
            if (obs_q.size() > 0)
                check_beat($sformatf("fixed_beat%0d", n), obs_q.pop_front(),
                           mk(8'h44, 64'h200, 8'(n), (n == 2), 1'b0));

        // Back-to-back: B accepted on A's last-beat edge, no bubble
        obs_q.delete();
        send_cmd(2'b01, 8'd1, 3'd2, 64'h100, 8'hA1);
        t0 = cyc;
        send_cmd(2'b01, 8'd0, 3'd2, 64'h500, 8'h22);
        t1 = cyc;
        check_val("b2b_accept_gap", 64'(t1 - t0), 64'd2);
        check_val("b2b_valid", 64'(beat_valid), 64'd1);
        check_beat("b2b_B_beat0", dut_beat(), mk(8'h22, 64'h500, 8'd0, 1'b1, 1'b0));
        wait_obs(3, "b2b");
        if (obs_q.size() >= 3) begin
            check_beat("b2b_A0", obs_q.pop_front(), mk(8'hA1, 64'h100, 8'd0, 1'b0, 1'b0));
            check_beat("b2b_A1", obs_q.pop_front(), mk(8'hA1, 64'h104, 8'd1, 1'b1, 1'b0));
            check_beat("b2b_B0", obs_q.pop_front(), mk(8'h22, 64'h500, 8'd0, 1'b1, 1'b0));
        end

        // Reset during beat 2 of an 8-beat INCR
        repeat (2) @(posedge aclk);
        #1;
        obs_q.delete();
        send_cmd(2'b01, 8'd7, 3'd2, 64'h1000, 8'h33);
        repeat (2) @(posedge aclk);
        #1;
        check_val("rstmid_idx_before", 64'(beat_index), 64'd2);
        areset = 1'b1;
        @(posedge aclk); #1;
        check_val("rstmid_valid", 64'(beat_valid), 64'd0);
        check_val("rstmid_cmd_ready", 64'(cmd_ready), 64'd0);
        check_beat("rstmid_beat", dut_beat(), mk(8'h0, 64'h0, 8'd0, 1'b0, 1'b0));
        areset = 1'b0;
        @(posedge aclk); #1;
        check_val("rstmid_valid_after", 64'(beat_valid), 64'd0);
        check_val("rstmid_beats_seen", 64'(obs_q.size()), 64'd2);
        obs_q.delete();
        send_cmd(2'b01, 8'd1, 3'd2, 64'h2004, 8'h05);
        check_beat("rstmid_new_beat0", dut_beat(), mk(8'h05, 64'h2004, 8'd0, 1'b0, 1'b0));
        wait_obs(2, "rstmid_new");
        if (obs_q.size() >= 2) begin
            check_beat("rstmid_new_b0", obs_q.pop_front(), mk(8'h05, 64'h2004, 8'd0, 1'b0, 1'b0));
            check_beat("rstmid_new_b1", obs_q.pop_front(), mk(8'h05, 64'h2008, 8'd1, 1'b1, 1'b0));
        end

        // Randomized commands with random beat_ready, scored against the model
        exp_q.delete();
        sb_on = 1;
        fork
            begin
                int lens[5] = '{0, 1, 3, 7, 15};
                logic [1:0]  bt;
                logic [7:0]  len;
                logic [2:0]  sz;
                logic [63:0] a;
                int r, c;
                for (int k = 0; k < 80; k++) begin
                    r   = $urandom_range(0, 9);
                    bt  = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
                    len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                                      : 8'(lens[$urandom_range(0, 4)]);
                    sz  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                    a   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 16'hFFFF));
                    send_cmd(bt, len, sz, a, 8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 4)) @(posedge aclk);
                        #1;
                    end
                end
                c = 0;
                while (exp_q.size() > 0 && c < 3000) begin
                    @(posedge aclk); #1;
                    c++;
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk); #1;
                    beat_ready = ($urandom_range(0, 9) < 7);
                end
                beat_ready = 1'b1;
            end
        join
        sb_on = 0;
        check_val("rand_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
